// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encoding and header address constants.
// Used by router_fsm, router_sync and router_reg.
package router_pkg;

   localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
   localparam logic [2:0] ST_LOAD_PARITY        = 3'd3;
   localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd4;
   localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd5;
   localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd6;
   localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd7;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = ST_DECODE_ADDRESS,
      LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
      LOAD_DATA          = ST_LOAD_DATA,
      LOAD_PARITY        = ST_LOAD_PARITY,
      FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
      LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
      WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY,
      CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR
   } state_t;

   localparam logic [1:0] ADDR_P0      = 2'd0;
   localparam logic [1:0] ADDR_P1      = 2'd1;
   localparam logic [1:0] ADDR_P2      = 2'd2;
   localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm_if.sv
// Control-plane bundle between the router FSM (slave) and its surroundings (master):
// packet/FIFO status in, state-decoded strobes out.
interface router_fsm_if;

   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;

   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic       rst_int_reg;
   logic       busy;

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
      input  write_enb_reg, rst_int_reg, busy
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
      output write_enb_reg, rst_int_reg, busy
   );

endinterface

// File: rtl/router_port_sel.sv
// Selects one FIFO's empty and soft-reset flags by 2-bit port address.
// The invalid address selects nothing, so both outputs read 0.
module router_port_sel
   import router_pkg::*;
(
   input  logic [1:0] addr,
   input  logic [2:0] empty,
   input  logic [2:0] soft_reset,
   output logic       empty_sel,
   output logic       soft_reset_sel
);

   always_comb begin
      empty_sel      = 1'b0;
      soft_reset_sel = 1'b0;
      case (addr)
         ADDR_P0: begin empty_sel = empty[0]; soft_reset_sel = soft_reset[0]; end
         ADDR_P1: begin empty_sel = empty[1]; soft_reset_sel = soft_reset[1]; end
         ADDR_P2: begin empty_sel = empty[2]; soft_reset_sel = soft_reset[2]; end
         default: begin empty_sel = 1'b0;     soft_reset_sel = 1'b0;          end
      endcase
   end

endmodule

// File: rtl/router_fsm.sv
// Packet-level controller of the 1x3 router (Moore FSM, outputs decoded from state only).
// Optional parity-check counter on err_cnt when ROUTER_FSM_ERR_CNT_EN is defined.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a valid header byte
// LOAD_FIRST_DATA    | header byte written to selected FIFO
// LOAD_DATA          | payload bytes streaming into FIFO
// FIFO_FULL_STATE    | stalled, selected FIFO full
// LOAD_AFTER_FULL    | write the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | register block compares parity
// WAIT_TILL_EMPTY    | target FIFO still draining a previous packet
module router_fsm
   import router_pkg::*;
`ifdef ROUTER_FSM_ERR_CNT_EN
#(
   parameter int ERR_CNT_W = 8
)
`endif
(
   input  logic  clock,
   input  logic  resetn,
   router_fsm_if.slave bus
`ifdef ROUTER_FSM_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   state_t     state;
   state_t     state_next;
   logic [1:0] addr_q;
   logic [1:0] sel_addr;
   logic       empty_sel;
   logic       soft_reset_sel;

   // While decoding, the incoming header picks the FIFO; afterwards the latched one does.
   assign sel_addr = (state == DECODE_ADDRESS) ? bus.data_in : addr_q;

   router_port_sel u_port_sel (
      .addr           (sel_addr),
      .empty          ({bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0}),
      .soft_reset     ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}),
      .empty_sel      (empty_sel),
      .soft_reset_sel (soft_reset_sel)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state  <= DECODE_ADDRESS;
         addr_q <= ADDR_P0;
      end else begin
         state <= state_next;
         if (state == DECODE_ADDRESS && bus.pkt_valid && bus.data_in != ADDR_INVALID)
            addr_q <= bus.data_in;
      end
   end

   always_comb begin
      state_next = state;
      if (state != DECODE_ADDRESS && soft_reset_sel) begin
         state_next = DECODE_ADDRESS;
      end else begin
         case (state)
            DECODE_ADDRESS:
               if (bus.pkt_valid && bus.data_in != ADDR_INVALID)
                  state_next = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    state_next = LOAD_DATA;
            LOAD_DATA:
               if (bus.fifo_full)       state_next = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_next = LOAD_PARITY;
            FIFO_FULL_STATE:
               if (!bus.fifo_full)      state_next = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
               if (bus.parity_done)        state_next = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_next = LOAD_PARITY;
               else                        state_next = LOAD_DATA;
            LOAD_PARITY:        state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
               if (empty_sel)           state_next = LOAD_FIRST_DATA;
            default:            state_next = DECODE_ADDRESS;
         endcase
      end
   end

   always_comb begin
      bus.detect_add    = (state == DECODE_ADDRESS);
      bus.lfd_state     = (state == LOAD_FIRST_DATA);
      bus.ld_state      = (state == LOAD_DATA);
      bus.laf_state     = (state == LOAD_AFTER_FULL);
      bus.full_state    = (state == FIFO_FULL_STATE);
      bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                          (state == LOAD_AFTER_FULL);
      bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
      bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
   end

`ifdef ROUTER_FSM_ERR_CNT_EN
   // Saturating; only the global reset clears it, soft resets leave the history intact.
   always_ff @(posedge clock) begin
      if (!resetn)
         err_cnt <= '0;
      else if (state == CHECK_PARITY_ERROR && err_cnt != {ERR_CNT_W{1'b1}})
         err_cnt <= err_cnt + ERR_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
module tb_router_fsm;

   localparam int M_DEC = 0, M_LFD = 1, M_LD = 2, M_LAF = 3,
                  M_FULL = 4, M_LP = 5, M_CPE = 6, M_WTE = 7;
   localparam int ERR_MAX = 255;

   // flag vector order: detect_add lfd ld laf full write_enb rst_int busy
   localparam logic [7:0] F_DEC  = 8'b1000_0000;
   localparam logic [7:0] F_LFD  = 8'b0100_0001;
   localparam logic [7:0] F_LD   = 8'b0010_0100;
   localparam logic [7:0] F_LAF  = 8'b0001_0101;
   localparam logic [7:0] F_FULL = 8'b0000_1001;
   localparam logic [7:0] F_LP   = 8'b0000_0101;
   localparam logic [7:0] F_CPE  = 8'b0000_0011;
   localparam logic [7:0] F_WTE  = 8'b0000_0001;

   logic clock = 1'b0;
   logic resetn;
   int   errors = 0;
   int   checks = 0;

   int         m_st   = M_DEC;
   logic [1:0] m_addr = 2'd0;
   int         m_err  = 0;

   router_fsm_if bus();

`ifdef ROUTER_FSM_ERR_CNT_EN
   logic [7:0] err_cnt;
   router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus), .err_cnt(err_cnt));
`else
   router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));
`endif

   always #5 clock = ~clock;

   function automatic logic [7:0] dut_flags();
      return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
   endfunction

   function automatic logic [7:0] exp_flags(int st);
      case (st)
         M_DEC:   return F_DEC;
         M_LFD:   return F_LFD;
         M_LD:    return F_LD;
         M_LAF:   return F_LAF;
         M_FULL:  return F_FULL;
         M_LP:    return F_LP;
         M_CPE:   return F_CPE;
         default: return F_WTE;
      endcase
   endfunction

   // Advance one clock; the reference model follows the packet rules using the inputs seen at the edge.
   task automatic step();
      int         ns;
      logic [1:0] na;
      int         ne;
      logic [2:0] emp;
      logic [2:0] sr;
      emp = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
      sr  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      ns = m_st; na = m_addr; ne = m_err;
      if (!resetn) begin
         ns = M_DEC; na = 2'd0; ne = 0;
      end else begin
         if (m_st == M_CPE && m_err < ERR_MAX) ne = m_err + 1;
         if (m_st != M_DEC && m_addr != 2'd3 && sr[m_addr]) ns = M_DEC;
         else case (m_st)
            M_DEC:  if (bus.pkt_valid && bus.data_in != 2'd3) begin
                       na = bus.data_in;
                       ns = emp[bus.data_in] ? M_LFD : M_WTE;
                    end
            M_LFD:  ns = M_LD;
            M_LD:   ns = bus.fifo_full ? M_FULL : (!bus.pkt_valid ? M_LP : M_LD);
            M_FULL: ns = bus.fifo_full ? M_FULL : M_LAF;
            M_LAF:  ns = bus.parity_done ? M_DEC : (bus.low_pkt_valid ? M_LP : M_LD);
            M_LP:   ns = M_CPE;
            M_CPE:  ns = bus.fifo_full ? M_FULL : M_DEC;
            default: ns = emp[m_addr] ? M_LFD : M_WTE;
         endcase
      end
      @(posedge clock);
      m_st = ns; m_addr = na; m_err = ne;
      #1;
   endtask

   task automatic clear_inputs();
      bus.pkt_valid = 0; bus.data_in = 0; bus.fifo_full = 0;
      bus.fifo_empty_0 = 0; bus.fifo_empty_1 = 0; bus.fifo_empty_2 = 0;
      bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
      bus.parity_done = 0; bus.low_pkt_valid = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetn = 0;
      step(); step();
      resetn = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dut_flags() !== F_DEC) begin
         errors++; $display("FAIL reset_flags: got=%b want=%b", dut_flags(), F_DEC);
      end
`ifdef ROUTER_FSM_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_err_cnt: got=%0d want=0", err_cnt);
      end
`endif
   endtask

   task automatic test_basic_packet();
      do_reset();
      bus.pkt_valid = 1; bus.data_in = 2'b01; bus.fifo_empty_1 = 1;
      step();
      checks++;
      if (dut_flags() !== F_LFD) begin
         errors++; $display("FAIL basic_lfd: got=%b want=%b", dut_flags(), F_LFD);
      end
      step();
      checks++;
      if (dut_flags() !== F_LD) begin
         errors++; $display("FAIL basic_ld: got=%b want=%b", dut_flags(), F_LD);
      end
      bus.pkt_valid = 0;
      step();
      checks++;
      if (dut_flags() !== F_LP) begin
         errors++; $display("FAIL basic_parity: got=%b want=%b", dut_flags(), F_LP);
      end
      step();
      checks++;
      if (dut_flags() !== F_CPE) begin
         errors++; $display("FAIL basic_check: got=%b want=%b", dut_flags(), F_CPE);
      end
      step();
      checks++;
      if (dut_flags() !== F_DEC) begin
         errors++; $display("FAIL basic_done: got=%b want=%b", dut_flags(), F_DEC);
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      bus.pkt_valid = 1; bus.data_in = 2'b01; bus.fifo_empty_1 = 1;
      step(); step();
      bus.fifo_full = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (dut_flags() !== F_FULL) begin
            errors++; $display("FAIL stall_full[%0d]: got=%b want=%b", i, dut_flags(), F_FULL);
         end
      end
      bus.fifo_full = 0;
      step();
      checks++;
      if (dut_flags() !== F_LAF) begin
         errors++; $display("FAIL stall_laf: got=%b want=%b", dut_flags(), F_LAF);
      end
      step();
      checks++;
      if (dut_flags() !== F_LD) begin
         errors++; $display("FAIL stall_resume: got=%b want=%b", dut_flags(), F_LD);
      end
      bus.pkt_valid = 0;
      step(); step(); step();
   endtask

   task automatic test_wait_empty();
      do_reset();
      bus.pkt_valid = 1; bus.data_in = 2'b10; bus.fifo_empty_2 = 0;
      bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (dut_flags() !== F_WTE) begin
            errors++; $display("FAIL wait_empty[%0d]: got=%b want=%b", i, dut_flags(), F_WTE);
         end
      end
      bus.fifo_empty_2 = 1;
      step();
      checks++;
      if (dut_flags() !== F_LFD) begin
         errors++; $display("FAIL wait_release: got=%b want=%b", dut_flags(), F_LFD);
      end
      bus.pkt_valid = 0;
      step(); step(); step(); step();
   endtask

   task automatic test_soft_reset();
      do_reset();
      bus.pkt_valid = 1; bus.data_in = 2'b00; bus.fifo_empty_0 = 1;
      step(); step();
      bus.soft_reset_1 = 1;
      step();
      checks++;
      if (dut_flags() !== F_LD) begin
         errors++; $display("FAIL soft_other_port: got=%b want=%b", dut_flags(), F_LD);
      end
      bus.soft_reset_0 = 1;
      step();
      checks++;
      if (dut_flags() !== F_DEC) begin
         errors++; $display("FAIL soft_own_port: got=%b want=%b", dut_flags(), F_DEC);
      end
      clear_inputs();
   endtask

   task automatic test_invalid_addr();
      do_reset();
      bus.pkt_valid = 1; bus.data_in = 2'b11;
      bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (dut_flags() !== F_DEC) begin
            errors++; $display("FAIL invalid_addr[%0d]: got=%b want=%b", i, dut_flags(), F_DEC);
         end
      end
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         resetn            = ($urandom_range(0, 199) != 0);
         bus.pkt_valid     = ($urandom_range(0, 9) < 7);
         bus.data_in       = 2'($urandom_range(0, 3));
         bus.fifo_full     = ($urandom_range(0, 3) == 0);
         bus.fifo_empty_0  = $urandom_range(0, 1) == 1;
         bus.fifo_empty_1  = $urandom_range(0, 1) == 1;
         bus.fifo_empty_2  = $urandom_range(0, 1) == 1;
         bus.soft_reset_0  = ($urandom_range(0, 39) == 0);
         bus.soft_reset_1  = ($urandom_range(0, 39) == 0);
         bus.soft_reset_2  = ($urandom_range(0, 39) == 0);
         bus.parity_done   = ($urandom_range(0, 4) == 0);
         bus.low_pkt_valid = ($urandom_range(0, 4) == 0);
         step();
         checks++;
         if (dut_flags() !== exp_flags(m_st)) begin
            errors++;
            $display("FAIL random_flags cycle %0d: got=%b want=%b", i, dut_flags(), exp_flags(m_st));
         end
`ifdef ROUTER_FSM_ERR_CNT_EN
         checks++;
         if (err_cnt !== 8'(m_err)) begin
            errors++; $display("FAIL random_err_cnt cycle %0d: got=%0d want=%0d", i, err_cnt, m_err);
         end
`endif
      end
      resetn = 1;
      clear_inputs();
   endtask

`ifdef ROUTER_FSM_ERR_CNT_EN
   task automatic test_err_cnt();
      do_reset();
      for (int p = 1; p <= 300; p++) begin
         bus.pkt_valid = 1; bus.data_in = 2'b00; bus.fifo_empty_0 = 1;
         step();
         bus.pkt_valid = 0;
         step(); step(); step(); step();
         if (p == 10) begin
            checks++;
            if (err_cnt !== 8'd10) begin
               errors++; $display("FAIL err_cnt_10: got=%0d want=10", err_cnt);
            end
         end
      end
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++; $display("FAIL err_cnt_saturate: got=%0d want=255", err_cnt);
      end
   endtask
`endif

   initial begin
      resetn = 0;
      clear_inputs();
      test_reset();
      test_basic_packet();
      test_full_stall();
      test_wait_empty();
      test_soft_reset();
      test_invalid_addr();
      test_random();
`ifdef ROUTER_FSM_ERR_CNT_EN
      test_err_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
